// File: rtl/hk_spi_pkg.sv
// Shared types and command-byte field definitions for the housekeeping SPI target.
package hk_spi_pkg;

    // Transaction phase.
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_e;

    // Command byte layout: [7] write, [6] read, [5:3] byte count (0 = stream), [2:0] ignored.
    localparam int unsigned CMD_WR_BIT  = 7;
    localparam int unsigned CMD_RD_BIT  = 6;
    localparam int unsigned CMD_CNT_MSB = 5;
    localparam int unsigned CMD_CNT_LSB = 3;

    localparam logic [7:0] CMD_READ  = 8'h40;
    localparam logic [7:0] CMD_WRITE = 8'h80;
    localparam logic [7:0] CMD_RDWR  = 8'hC0;

    // A command is usable only if it requests a read, a write, or both.
    function automatic logic cmd_valid(input logic [7:0] cmd);
        return (cmd & (CMD_READ | CMD_WRITE)) != 8'h00;
    endfunction

endpackage

// File: rtl/hk_spi_if.sv
// Pad-side SPI pins plus the register-bank access bus of the housekeeping SPI target.
interface hk_spi_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              sck;
    logic              csb;
    logic              sdi;
    logic              sdo;
    logic              sdo_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              busy;

    // Responder side.
    modport slave (
        input  sck, csb, sdi, reg_rdata,
        output sdo, sdo_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    // Host pins and register bank side.
    modport master (
        output sck, csb, sdi, reg_rdata,
        input  sdo, sdo_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );
endinterface

// File: rtl/hk_spi_sync.sv
// Input conditioning for the SPI pins: optional synchroniser chain (HK_SPI_SYNC_EN)
// followed by a one-flop SCK edge detector. CSB/SDI share the chain but need no edges.
module hk_spi_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic sck,
    input  logic csb,
    input  logic sdi,
    output logic csb_s,
    output logic sdi_s,
    output logic sck_rise,
    output logic sck_fall
);
`ifdef HK_SPI_SYNC_EN
    localparam int unsigned SyncOn = 1;
`else
    localparam int unsigned SyncOn = 0;
`endif
    localparam int unsigned Depth = STAGES * SyncOn;

    logic [2:0] pins_s;  // {sck, csb, sdi}
    logic       sck_q;

    if (Depth == 0) begin : g_direct
        assign pins_s = {sck, csb, sdi};
    end else begin : g_chain
        logic [2:0] chain_q [Depth];

        // Shift raw pins through the chain; CSB resets deasserted so reset looks idle.
        always_ff @(posedge clock or negedge resetb) begin
            if (!resetb) begin
                for (int unsigned i = 0; i < Depth; i++) chain_q[i] <= 3'b010;
            end else begin
                chain_q[0] <= {sck, csb, sdi};
                for (int unsigned i = 1; i < Depth; i++) chain_q[i] <= chain_q[i-1];
            end
        end

        assign pins_s = chain_q[Depth-1];
    end

    // Delay flop for SCK edge detection.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) sck_q <= 1'b0;
        else         sck_q <= pins_s[2];
    end

    assign csb_s    = pins_s[1];
    assign sdi_s    = pins_s[0];
    assign sck_rise = pins_s[2] & ~sck_q;
    assign sck_fall = ~pins_s[2] & sck_q;
endmodule

// File: rtl/hk_spi_target.sv
// Housekeeping SPI target: decodes the host command/address/data byte stream into
// single-cycle register reads and writes. Synchroniser depth is set by HK_SPI_SYNC_EN.
module hk_spi_target
    import hk_spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic     clock,
    input logic     resetb,
    hk_spi_if.slave bus
);
    logic csb_s, sdi_s, sck_rise, sck_fall;

    state_e            state_q, state_d;
    logic [6:0]        rx_q;
    logic [2:0]        bit_cnt_q, byte_cnt_q;
    logic [7:3]        cmd_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [7:0]        reg_wdata_q, tx_q;
    logic              reg_we_q, reg_re_q, rd_cap_q, inc_pend_q, re_pend_q, sdo_oe_q;

    logic       active, shift_en, byte_done, last_byte, is_wr, is_rd;
    logic [7:0] rx_byte;
    logic [2:0] cnt;

    hk_spi_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .resetb  (resetb),
        .sck     (bus.sck),
        .csb     (bus.csb),
        .sdi     (bus.sdi),
        .csb_s   (csb_s),
        .sdi_s   (sdi_s),
        .sck_rise(sck_rise),
        .sck_fall(sck_fall)
    );

    assign active    = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    assign shift_en  = active && sck_rise && !csb_s;
    assign byte_done = shift_en && (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_q, sdi_s};
    assign is_wr     = cmd_q[CMD_WR_BIT];
    assign is_rd     = cmd_q[CMD_RD_BIT];
    assign cnt       = cmd_q[CMD_CNT_MSB:CMD_CNT_LSB];
    assign last_byte = (cnt != 3'd0) && ((byte_cnt_q + 3'd1) == cnt);

    // State register.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: CSB high always wins; otherwise advance on completed bytes.
    always_comb begin
        state_d = state_q;
        if (csb_s) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = CMD;
                CMD:  if (byte_done) state_d = cmd_valid(rx_byte) ? ADDR : DONE;
                ADDR: if (byte_done) state_d = DATA;
                DATA: if (byte_done && last_byte) state_d = DONE;
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath: bit/byte shifting, strobe scheduling and read-data pipeline.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            cmd_q       <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            tx_q        <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            rd_cap_q    <= 1'b0;
            inc_pend_q  <= 1'b0;
            re_pend_q   <= 1'b0;
            sdo_oe_q    <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;
            rd_cap_q <= reg_re_q;
            // Post-write increment; a read/write follows it with the read strobe.
            if (inc_pend_q) begin
                reg_addr_q <= reg_addr_q + ADDR_W'(1);
                reg_re_q   <= re_pend_q;
                inc_pend_q <= 1'b0;
                re_pend_q  <= 1'b0;
            end
            // reg_rdata is valid the clock after reg_re.
            if (rd_cap_q && state_q == DATA) begin
                tx_q     <= bus.reg_rdata;
                sdo_oe_q <= 1'b1;
            end
            if (csb_s) begin
                rx_q       <= '0;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                tx_q       <= '0;
                sdo_oe_q   <= 1'b0;
            end else begin
                if (shift_en) begin
                    rx_q      <= rx_byte[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                // The fall right after a byte boundary must keep the freshly loaded MSB.
                if (sck_fall && state_q == DATA && bit_cnt_q != 3'd0) begin
                    tx_q <= {tx_q[6:0], 1'b0};
                end
                if (byte_done) begin
                    case (state_q)
                        CMD: cmd_q <= rx_byte[7:3];
                        ADDR: begin
                            reg_addr_q <= ADDR_W'(rx_byte);
                            if (is_rd) reg_re_q <= 1'b1;
                        end
                        DATA: begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                            if (is_wr) begin
                                reg_wdata_q <= rx_byte;
                                reg_we_q    <= 1'b1;
                                inc_pend_q  <= 1'b1;
                                re_pend_q   <= is_rd && !last_byte;
                            end else if (!last_byte) begin
                                reg_addr_q <= reg_addr_q + ADDR_W'(1);
                                reg_re_q   <= 1'b1;
                            end
                            if (last_byte) begin
                                tx_q     <= '0;
                                sdo_oe_q <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Outputs: SDO gated by its enable so it reads 0 whenever undriven.
    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.sdo_oe    = sdo_oe_q;
        bus.sdo       = sdo_oe_q & tx_q[7];
        bus.reg_addr  = reg_addr_q;
        bus.reg_wdata = reg_wdata_q;
        bus.reg_we    = reg_we_q;
        bus.reg_re    = reg_re_q;
    end
endmodule
